// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_arbiter
// Purpose  : Shares one fixed-latency FPU between two requesters. Commands are
//            granted round-robin, issued one cycle after acceptance, and tagged
//            so that each result returns to its own requester's result FIFO.
//            Per-requester credits cover in-flight plus buffered results, so a
//            result always has a free FIFO slot when it lands.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            req_valid/req_ready    - per-requester command handshake (2 bits)
//            req_op/req_a/req_b     - packed per-requester opcode and operands
//            fpu_valid/op/a/b       - registered issue to the FPU
//            fpu_res_valid/fpu_res  - FPU result, LATENCY cycles after issue
//            rsp_valid/rsp_ready    - per-requester result handshake (2 bits)
//            rsp_data               - packed per-requester FIFO head
//            err                    - sticky result/tag mismatch flag
// Revision : 1.0 - initial release
// ============================================================================
module fpu_arbiter #(
    parameter int LATENCY = 12,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic        fpu_valid,
    output logic [1:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_res_valid,
    input  logic [31:0] fpu_res,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [63:0] rsp_data,
    output logic        err
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam int              c_cw    = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_one   = c_cw'(1);
    localparam logic [c_aw:0]   c_pinc  = (c_aw + 1)'(1);

    logic        r_ptr;        // favoured requester
    logic [1:0]  w_elig;
    logic        w_accept;
    logic        w_win_id;
    logic [1:0]  w_push;
    logic [1:0]  w_pop;

    logic        r_fpu_valid;
    logic        r_fpu_id;
    logic [1:0]  r_fpu_op;
    logic [31:0] r_fpu_a;
    logic [31:0] r_fpu_b;

    logic [LATENCY-1:0] r_tag_v;
    logic [LATENCY-1:0] r_tag_id;
    logic               w_tag_v;
    logic               w_tag_id;
    logic               r_err;

    // Grant: favoured requester if eligible, otherwise the other one. Nothing
    // is accepted while reset is asserted, so no command is silently dropped.
    always_comb begin
        w_accept  = !rst && (w_elig != 2'b00);
        w_win_id  = w_elig[r_ptr] ? r_ptr : ~r_ptr;
        req_ready = 2'b00;
        if (w_accept) begin
            req_ready[w_win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= 1'b0;
            r_fpu_valid <= 1'b0;
            r_fpu_id    <= 1'b0;
            r_fpu_op    <= 2'b00;
            r_fpu_a     <= 32'd0;
            r_fpu_b     <= 32'd0;
        end else begin
            r_fpu_valid <= w_accept;
            if (w_accept) begin
                r_ptr    <= ~w_win_id;
                r_fpu_id <= w_win_id;
                r_fpu_op <= req_op[{w_win_id, 1'b0} +: 2];
                r_fpu_a  <= req_a[{w_win_id, 5'd0} +: 32];
                r_fpu_b  <= req_b[{w_win_id, 5'd0} +: 32];
            end
        end
    end

    assign fpu_valid = r_fpu_valid;
    assign fpu_op    = r_fpu_op;
    assign fpu_a     = r_fpu_a;
    assign fpu_b     = r_fpu_b;

    // Tag pipe is fed from the issue register, so its last stage lines up with
    // the FPU result exactly LATENCY cycles after fpu_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v[0]  <= r_fpu_valid;
            r_tag_id[0] <= r_fpu_id;
            for (int j = 1; j < LATENCY; j++) begin
                r_tag_v[j]  <= r_tag_v[j-1];
                r_tag_id[j] <= r_tag_id[j-1];
            end
        end
    end

    assign w_tag_v  = r_tag_v[LATENCY-1];
    assign w_tag_id = r_tag_id[LATENCY-1];

    // A result without a tag, or a tag without a result, is a protocol error;
    // an untagged result has no owner and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (fpu_res_valid != w_tag_v) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    for (genvar i = 0; i < 2; i++) begin : g_req
        localparam logic c_id = 1'(i);

        logic [31:0]     r_mem [DEPTH];
        logic [c_aw:0]   r_wr;
        logic [c_aw:0]   r_rd;
        logic [c_cw-1:0] r_credit;

        assign w_elig[i] = req_valid[i] && (r_credit < c_depth);
        assign w_push[i] = fpu_res_valid && w_tag_v && (w_tag_id == c_id);
        assign w_pop[i]  = rsp_valid[i] && rsp_ready[i];

        assign rsp_valid[i]         = (r_wr != r_rd);
        assign rsp_data[32*i +: 32] = r_mem[r_rd[c_aw-1:0]];

        always_ff @(posedge clk) begin
            if (w_push[i]) begin
                r_mem[r_wr[c_aw-1:0]] <= fpu_res;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr <= '0;
                r_rd <= '0;
            end else begin
                if (w_push[i]) begin
                    r_wr <= r_wr + c_pinc;
                end
                if (w_pop[i]) begin
                    r_rd <= r_rd + c_pinc;
                end
            end
        end

        // Credit reserves a FIFO slot at accept time and releases it on pop.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_credit <= '0;
            end else if (req_ready[i] && !w_pop[i]) begin
                r_credit <= r_credit + c_one;
            end else if (!req_ready[i] && w_pop[i]) begin
                r_credit <= r_credit - c_one;
            end
        end
    end

endmodule
`default_nettype wire
